// File: rtl/imem_loader.sv
// Boot loader: receives a framed instruction image over a byte stream and writes it
// word by word into the processor's instruction memory while holding the CPU in reset.
module imem_loader #(
    parameter int DEPTH_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        prog,
    output logic        write,
    output logic [31:0] addr,
    output logic [31:0] data_o,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR0  = 3'd1;
    localparam logic [2:0] S_HDR1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_CSUM  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    localparam logic [32:0] CAPACITY = 33'(1) << DEPTH_W;

    logic [2:0]       state;
    logic [DEPTH_W:0] waddr;
    logic [15:0]      remaining;
    logic [7:0]       cnt_hi;
    logic [7:0]       sum;
    logic [1:0]       idx;
    logic [31:0]      word;

    logic        take;
    logic [7:0]  sum_next;
    logic [15:0] cnt;
    logic        too_big;

    assign take     = in_valid & in_ready;
    assign sum_next = sum + in_data;
    assign cnt      = {cnt_hi, in_data};
    assign too_big  = {17'd0, cnt} > CAPACITY;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            waddr     <= '0;
            word      <= '0;
            remaining <= '0;
            cnt_hi    <= '0;
            sum       <= '0;
            idx       <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state <= S_HDR0;
                        waddr <= '0;
                        sum   <= '0;
                        idx   <= '0;
                    end
                end
                S_HDR0: begin
                    if (take) begin
                        cnt_hi <= in_data;
                        sum    <= sum_next;
                        state  <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (take) begin
                        sum       <= sum_next;
                        remaining <= cnt;
                        if (too_big)
                            state <= S_ERR;
                        else if (cnt == 16'd0)
                            state <= S_CSUM;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (take) begin
                        sum  <= sum_next;
                        word <= {word[23:0], in_data};
                        idx  <= idx + 2'd1;
                        if (idx == 2'd3)
                            state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // addr/data_o stay stable for the whole strobe cycle; advance on exit
                    waddr     <= waddr + 1'b1;
                    remaining <= remaining - 16'd1;
                    state     <= (remaining == 16'd1) ? S_CSUM : S_DATA;
                end
                S_CSUM: begin
                    if (take) begin
                        sum   <= sum_next;
                        state <= (sum_next == 8'd0) ? S_DONE : S_ERR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_HDR0) || (state == S_HDR1) ||
                       (state == S_DATA) || (state == S_CSUM);
    assign busy      = in_ready || (state == S_WRITE);
    assign prog      = busy;
    // CPU stays held after a failed load so a partial image never runs
    assign cpu_reset = busy || (state == S_ERR);
    assign write     = (state == S_WRITE);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);
    assign addr      = 32'(waddr);
    assign data_o    = word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame-position reference model checked every cycle,
// plus literal expectations for the write log and final status of each scenario.
module tb_imem_loader;
    localparam int DW = 4;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, prog, write, cpu_reset, busy, done, err;
    logic [31:0] addr, data_o;

    imem_loader #(.DEPTH_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .prog(prog), .write(write),
        .addr(addr), .data_o(data_o), .cpu_reset(cpu_reset), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int busy_cycles = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [7:0]  frame[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within the frame rather than a state encoding
    bit          m_active, m_wr;
    int          m_result, m_pos, m_n;
    logic [7:0]  m_sum, m_hi;
    logic [31:0] m_addr, m_data;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0; m_result = 0; m_wr = 0; m_pos = 0;
            m_sum = 0; m_addr = 0; m_data = 0;
        end else if (m_wr) begin
            m_wr = 0;
            m_addr = m_addr + 1;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_result = 0; m_addr = 0; m_pos = 0; m_sum = 0;
            end
        end else if (in_valid) begin
            m_sum = m_sum + in_data;
            m_pos++;
            if (m_pos == 1) begin
                m_hi = in_data;
            end else if (m_pos == 2) begin
                m_n = int'({m_hi, in_data});
                if (m_n > (1 << DW)) begin
                    m_active = 0; m_result = 2;
                end
            end else if (m_pos <= 2 + 4 * m_n) begin
                m_data = {m_data[23:0], in_data};
                if ((m_pos - 2) % 4 == 0) m_wr = 1;
            end else begin
                m_active = 0;
                m_result = (m_sum == 8'd0) ? 1 : 2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  32'(in_ready),  32'(m_active && !m_wr));
            chk("prog",      32'(prog),      32'(m_active));
            chk("busy",      32'(busy),      32'(m_active));
            chk("cpu_reset", 32'(cpu_reset), 32'(m_active || m_result == 2));
            chk("write",     32'(write),     32'(m_wr));
            chk("done",      32'(done),      32'(m_result == 1));
            chk("err",       32'(err),       32'(m_result == 2));
            chk("addr",      addr,           m_addr);
            chk("data_o",    data_o,         m_data);
        end
        if (write) begin
            wa.push_back(addr);
            wd.push_back(data_o);
        end
        if (busy) busy_cycles++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        bit acc;
        t = 0;
        in_valid = 1'b1;
        in_data = b;
        do begin
            acc = in_ready;
            tick();
            t++;
        end while (!acc && t < 20);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout byte=%h", b);
        end
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input bit stall);
        foreach (frame[i]) send(frame[i], stall ? int'($urandom_range(1, 3)) : 0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 200) begin
            tick();
            t++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL wait_idle_timeout busy=%b", busy);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        busy_cycles = 0;
    endtask

    task automatic check_good_writes(input string tag);
        chk({tag, "_nwrites"}, 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk({tag, "_addr0"}, wa[0], 32'd0);
            chk({tag, "_data0"}, wd[0], 32'h12345678);
            chk({tag, "_addr1"}, wa[1], 32'd1);
            chk({tag, "_data1"}, wd[1], 32'h9ABCDEF0);
        end
    endtask

    initial begin
        logic [7:0] s, b;
        logic [31:0] last_word;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_data_o", data_o, 32'd0);
        reset = 1'b0;
        tick();

        // good load
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hC6};
        clear_log();
        do_start();
        send_frame(1'b0);
        wait_idle();
        check_good_writes("good");
        chk("good_done", 32'(done), 32'd1);
        chk("good_prog", 32'(prog), 32'd0);
        chk("good_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("good_busy_cycles", 32'(busy_cycles), 32'd13);
        tick();

        // bad checksum
        frame[10] = 8'hC7;
        clear_log();
        do_start();
        send_frame(1'b0);
        wait_idle();
        check_good_writes("bad");
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("bad_prog", 32'(prog), 32'd0);
        chk("bad_done", 32'(done), 32'd0);
        tick();

        // empty image
        frame = '{8'h00, 8'h00, 8'h00};
        clear_log();
        do_start();
        send_frame(1'b0);
        wait_idle();
        chk("empty_nwrites", 32'(wa.size()), 32'd0);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_err", 32'(err), 32'd0);

        // stalled stream
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hC6};
        clear_log();
        do_start();
        send_frame(1'b1);
        wait_idle();
        check_good_writes("stall");
        chk("stall_done", 32'(done), 32'd1);

        // reset after 6 data bytes
        clear_log();
        do_start();
        for (int i = 0; i < 8; i++) send(frame[i], 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        chk("mid_prog", 32'(prog), 32'd0);
        chk("mid_write", 32'(write), 32'd0);
        chk("mid_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        chk("mid_addr", addr, 32'd0);
        chk("mid_data_o", data_o, 32'd0);
        tick();
        clear_log();
        do_start();
        send_frame(1'b0);
        wait_idle();
        check_good_writes("after_rst");
        chk("after_rst_done", 32'(done), 32'd1);

        // over capacity: 17 words with 16-word memory
        clear_log();
        do_start();
        send(8'h00, 0);
        send(8'h11, 0);
        chk("cap_err", 32'(err), 32'd1);
        chk("cap_in_ready", 32'(in_ready), 32'd0);
        chk("cap_busy", 32'(busy), 32'd0);
        tick();
        chk("cap_nwrites", 32'(wa.size()), 32'd0);

        // exactly full: 16 words
        frame = '{8'h00, 8'h10};
        s = 8'h10;
        last_word = '0;
        for (int i = 0; i < 64; i++) begin
            b = 8'(i * 7 + 3);
            frame.push_back(b);
            s = s + b;
            if (i >= 60) last_word = {last_word[23:0], b};
        end
        frame.push_back(8'h00 - s);
        clear_log();
        do_start();
        send_frame(1'b0);
        wait_idle();
        chk("full_nwrites", 32'(wa.size()), 32'd16);
        if (wa.size() == 16) begin
            chk("full_addr15", wa[15], 32'd15);
            chk("full_data15", wd[15], last_word);
        end
        chk("full_done", 32'(done), 32'd1);

        // start while busy is ignored
        clear_log();
        do_start();
        send(8'h00, 0); send(8'h01, 0); send(8'h12, 0); send(8'h34, 0);
        do_start();
        send(8'h56, 0); send(8'h78, 0); send(8'hEB, 0);
        wait_idle();
        chk("ign_nwrites", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            chk("ign_addr0", wa[0], 32'd0);
            chk("ign_data0", wd[0], 32'h12345678);
        end
        chk("ign_done", 32'(done), 32'd1);
        tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
